// File: rtl/cordic_rr_scheduler.sv
// Round-robin front end sharing one pipelined Cordic among NREQ requesters; converts degrees to phase
// words, tracks in-flight tags and routes results back. Build option: CORDIC_SCHED_WRAP_EN.
module cordic_rr_scheduler #(
   parameter int unsigned NREQ       = 4,
   parameter int unsigned CORDIC_LAT = 16,
   parameter int unsigned TAG_W      = 3
) (
   input  logic                 CLK_50M,
   input  logic                 RST,
   input  logic [NREQ-1:0]      req_i,
   input  logic [9*NREQ-1:0]    deg_i,
   output logic [NREQ-1:0]      gnt_o,
   output logic [31:0]          Phase,
   input  logic [31:0]          cordic_sin_i,
   input  logic [31:0]          cordic_cos_i,
   output logic [NREQ-1:0]      rsp_vld_o,
   output logic [31:0]          sin_o,
   output logic [31:0]          cos_o,
   output logic                 busy_o
);

   localparam int unsigned DEG_W  = 9;
   localparam int unsigned DATA_W = 32;

   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [DATA_W-1:0] phase_q, phase_d;
   logic [NREQ-1:0]   rsp_q, rsp_d;
   logic [DATA_W-1:0] sin_q, sin_d, cos_q, cos_d;
   logic              busy_q, busy_d;
   logic [TAG_W-1:0]  ptr_q, ptr_d;
   logic [NREQ-1:0]   pend_q, pend_d;

   // Entry 0 is concurrent with Phase; entry CORDIC_LAT meets the Cordic outputs.
   logic [CORDIC_LAT:0] pipe_vld_q;
   logic [TAG_W-1:0]    pipe_tag_q [CORDIC_LAT+1];

   logic [NREQ-1:0]   elig_c;
   logic              found_c;
   logic [TAG_W-1:0]  sel_c, cand_c;
   logic [DEG_W-1:0]  deg_sel_c, deg_eff_c;
   logic              sel_oor_c, issue_c, err_c, cap_c;
   logic [TAG_W-1:0]  cap_tag_c;
`ifndef CORDIC_SCHED_WRAP_EN
   logic [NREQ-1:0]   oor_c;
`endif

   function automatic logic [NREQ-1:0] onehot(input logic [TAG_W-1:0] t);
      logic [NREQ-1:0] v;
      v = '0;
      for (int unsigned k = 0; k < NREQ; k++)
         v[k] = (t == TAG_W'(k));
      return v;
   endfunction

   function automatic logic [DATA_W-1:0] deg2phase(input logic [DEG_W-1:0] d);
      logic [1:0]       q;
      logic [DEG_W-1:0] off;
      if (d <= DEG_W'(90)) begin
         q   = 2'b00;
         off = d;
      end else if (d <= DEG_W'(180)) begin
         q   = 2'b01;
         off = d - DEG_W'(90);
      end else if (d <= DEG_W'(270)) begin
         q   = 2'b10;
         off = d - DEG_W'(180);
      end else begin
         q   = 2'b11;
         off = d - DEG_W'(270);
      end
      return {14'd0, q, 16'(off)};
   endfunction

   assign cap_c     = pipe_vld_q[CORDIC_LAT];
   assign cap_tag_c = pipe_tag_q[CORDIC_LAT];

   // Eligibility and rotating-priority search starting at ptr_q.
   always_comb begin
      elig_c = req_i & ~pend_q;
`ifndef CORDIC_SCHED_WRAP_EN
      oor_c = '0;
      for (int unsigned k = 0; k < NREQ; k++)
         oor_c[k] = (deg_i[DEG_W*k +: DEG_W] >= DEG_W'(360));
      // An out-of-range reply would collide with a pipeline result on rsp_vld_o; defer it a cycle.
      elig_c = elig_c & ~(oor_c & {NREQ{cap_c}});
`endif
      found_c = 1'b0;
      sel_c   = '0;
      cand_c  = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         cand_c = TAG_W'((32'(ptr_q) + i) % NREQ);
         for (int unsigned k = 0; k < NREQ; k++) begin
            if (!found_c && elig_c[k] && (cand_c == TAG_W'(k))) begin
               found_c = 1'b1;
               sel_c   = cand_c;
            end
         end
      end
   end

   // Angle of the selected requester and its reduction / rejection.
   always_comb begin
      deg_sel_c = '0;
      for (int unsigned k = 0; k < NREQ; k++)
         if (sel_c == TAG_W'(k))
            deg_sel_c = deg_i[DEG_W*k +: DEG_W];
      sel_oor_c = (deg_sel_c >= DEG_W'(360));
`ifdef CORDIC_SCHED_WRAP_EN
      deg_eff_c = sel_oor_c ? (deg_sel_c - DEG_W'(360)) : deg_sel_c;
      issue_c   = found_c;
      err_c     = 1'b0;
`else
      deg_eff_c = deg_sel_c;
      issue_c   = found_c & ~sel_oor_c;
      err_c     = found_c & sel_oor_c;
`endif
   end

   // Next-state for grant, phase, pending mask and response registers.
   always_comb begin
      gnt_d   = '0;
      phase_d = phase_q;
      ptr_d   = ptr_q;
      pend_d  = pend_q;
      rsp_d   = '0;
      sin_d   = sin_q;
      cos_d   = cos_q;
      if (found_c) begin
         gnt_d = onehot(sel_c);
         ptr_d = (sel_c == TAG_W'(NREQ-1)) ? '0 : sel_c + TAG_W'(1);
      end
      if (issue_c) begin
         phase_d = deg2phase(deg_eff_c);
         pend_d  = pend_d | onehot(sel_c);
      end
      if (cap_c) begin
         rsp_d  = onehot(cap_tag_c);
         sin_d  = cordic_sin_i;
         cos_d  = cordic_cos_i;
         pend_d = pend_d & ~onehot(cap_tag_c);
      end else if (err_c) begin
         rsp_d = onehot(sel_c);
         sin_d = '1;
         cos_d = '1;
      end
      busy_d = |pend_d;
   end

   always_ff @(posedge CLK_50M) begin
      if (RST) begin
         gnt_q   <= '0;
         phase_q <= '0;
         rsp_q   <= '0;
         sin_q   <= '0;
         cos_q   <= '0;
         busy_q  <= 1'b0;
         ptr_q   <= '0;
         pend_q  <= '0;
      end else begin
         gnt_q   <= gnt_d;
         phase_q <= phase_d;
         rsp_q   <= rsp_d;
         sin_q   <= sin_d;
         cos_q   <= cos_d;
         busy_q  <= busy_d;
         ptr_q   <= ptr_d;
         pend_q  <= pend_d;
      end
   end

   // Tag pipeline tracking issued phases through the Cordic latency.
   always_ff @(posedge CLK_50M) begin
      if (RST) begin
         pipe_vld_q <= '0;
         for (int unsigned i = 0; i <= CORDIC_LAT; i++)
            pipe_tag_q[i] <= '0;
      end else begin
         pipe_vld_q    <= {pipe_vld_q[CORDIC_LAT-1:0], issue_c};
         pipe_tag_q[0] <= sel_c;
         for (int unsigned i = 1; i <= CORDIC_LAT; i++)
            pipe_tag_q[i] <= pipe_tag_q[i-1];
      end
   end

   assign gnt_o     = gnt_q;
   assign Phase     = phase_q;
   assign rsp_vld_o = rsp_q;
   assign sin_o     = sin_q;
   assign cos_o     = cos_q;
   assign busy_o    = busy_q;

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// Directed bench for cordic_rr_scheduler with a delay-line Cordic stand-in.
module tb_cordic_rr_scheduler;

   localparam int unsigned NREQ = 4;
   localparam int unsigned LAT  = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_i;
   logic [9*NREQ-1:0] deg_i;
   logic [NREQ-1:0]   gnt_o;
   logic [31:0]       phase;
   logic [31:0]       cordic_sin_i, cordic_cos_i;
   logic [NREQ-1:0]   rsp_vld_o;
   logic [31:0]       sin_o, cos_o;
   logic              busy_o;

   int n_vec = 0;
   int n_err = 0;

   always #10 clk = ~clk;

   cordic_rr_scheduler #(.NREQ(NREQ), .CORDIC_LAT(LAT), .TAG_W(3)) dut (
      .CLK_50M      (clk),
      .RST          (rst),
      .req_i        (req_i),
      .deg_i        (deg_i),
      .gnt_o        (gnt_o),
      .Phase        (phase),
      .cordic_sin_i (cordic_sin_i),
      .cordic_cos_i (cordic_cos_i),
      .rsp_vld_o    (rsp_vld_o),
      .sin_o        (sin_o),
      .cos_o        (cos_o),
      .busy_o       (busy_o)
   );

   function automatic logic [31:0] fsin(input logic [31:0] p);
      return p ^ 32'hDEAD_0000;
   endfunction

   function automatic logic [31:0] fcos(input logic [31:0] p);
      return p + 32'h0100_0000;
   endfunction

   // Cordic stand-in: outputs describe the Phase driven LAT cycles earlier.
   logic [31:0] ph_hist [LAT];
   always @(posedge clk) begin
      ph_hist[0] <= phase;
      for (int i = 1; i < LAT; i++) ph_hist[i] <= ph_hist[i-1];
   end
   assign cordic_sin_i = fsin(ph_hist[LAT-1]);
   assign cordic_cos_i = fcos(ph_hist[LAT-1]);

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      rst   = 1'b1;
      req_i = '0;
      repeat (n) tick();
      rst = 1'b0;
   endtask

   task automatic wait_rsp(output int cyc);
      cyc = 0;
      while (rsp_vld_o == '0 && cyc < 40) begin
         tick();
         cyc++;
      end
   endtask

   // All four requesters asserted from ptr 0: grants 0..3, responses in order back-to-back.
   task automatic run_rr(input logic [35:0] degs, input logic [127:0] ph, input string tag);
      int n;
      do_reset(2);
      deg_i = degs;
      req_i = 4'hF;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_vec({tag, "_gnt"}, 32'(gnt_o), 32'(1) << i);
         check_vec({tag, "_phase"}, phase, ph[32*i +: 32]);
      end
      req_i = '0;
      wait_rsp(n);
      check_vec({tag, "_lat"}, 32'(n), 32'd14);
      for (int i = 0; i < 4; i++) begin
         check_vec({tag, "_rsp"}, 32'(rsp_vld_o), 32'(1) << i);
         check_vec({tag, "_sin"}, sin_o, fsin(ph[32*i +: 32]));
         check_vec({tag, "_cos"}, cos_o, fcos(ph[32*i +: 32]));
         tick();
      end
      check_vec({tag, "_rsp_end"}, 32'(rsp_vld_o), 32'd0);
      check_vec({tag, "_busy_end"}, 32'(busy_o), 32'd0);
   endtask

   initial begin
      int n;
      int hits;
      rst   = 1'b1;
      req_i = 4'hF;
      deg_i = '0;

      // Reset with requests asserted
      repeat (3) tick();
      check_vec("rst_gnt", 32'(gnt_o), 32'd0);
      check_vec("rst_rsp", 32'(rsp_vld_o), 32'd0);
      check_vec("rst_phase", phase, 32'd0);
      check_vec("rst_busy", 32'(busy_o), 32'd0);
      check_vec("rst_sin", sin_o, 32'd0);
      rst   = 1'b0;
      req_i = '0;
      tick();

      // Single request, 135 degrees
      deg_i[8:0] = 9'd135;
      req_i      = 4'b0001;
      tick();
      check_vec("one_gnt", 32'(gnt_o), 32'h1);
      check_vec("one_phase", phase, 32'h0001_002D);
      check_vec("one_busy", 32'(busy_o), 32'd1);
      req_i = '0;
      wait_rsp(n);
      check_vec("one_lat", 32'(n), 32'd17);
      check_vec("one_rsp", 32'(rsp_vld_o), 32'h1);
      check_vec("one_sin", sin_o, fsin(32'h0001_002D));
      check_vec("one_cos", cos_o, fcos(32'h0001_002D));
      check_vec("one_busy_end", 32'(busy_o), 32'd0);
      tick();
      check_vec("one_rsp_pulse", 32'(rsp_vld_o), 32'd0);

      // Round robin, quadrant boundaries
      run_rr({9'd359, 9'd181, 9'd90, 9'd0},
             {32'h0003_0059, 32'h0002_0001, 32'h0000_005A, 32'h0000_0000}, "rr");
      run_rr({9'd271, 9'd270, 9'd180, 9'd91},
             {32'h0003_0001, 32'h0002_005A, 32'h0001_005A, 32'h0001_0001}, "bnd");

      // Outstanding block: req0 held, regrant only after the response
      do_reset(2);
      deg_i[8:0] = 9'd45;
      req_i      = 4'b0001;
      tick();
      check_vec("hold_gnt0", 32'(gnt_o), 32'h1);
      for (int c = 1; c <= 17; c++) begin
         tick();
         check_vec("hold_gnt", 32'(gnt_o), 32'd0);
         check_vec("hold_busy", 32'(busy_o), (c < 17) ? 32'd1 : 32'd0);
         check_vec("hold_rsp", 32'(rsp_vld_o), (c < 17) ? 32'd0 : 32'd1);
      end
      tick();
      check_vec("hold_regnt", 32'(gnt_o), 32'h1);
      check_vec("hold_rebusy", 32'(busy_o), 32'd1);
      req_i = '0;

      // Mid-flight reset discards results and clears the pointer
      do_reset(2);
      deg_i = {9'd359, 9'd181, 9'd90, 9'd0};
      req_i = 4'hF;
      repeat (3) tick();
      check_vec("mid_gnt3", 32'(gnt_o), 32'h4);
      req_i = '0;
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_vec("mid_busy", 32'(busy_o), 32'd0);
      hits = 0;
      for (int c = 0; c < 30; c++) begin
         tick();
         if (rsp_vld_o != '0 || busy_o) hits++;
      end
      check_vec("mid_no_rsp", 32'(hits), 32'd0);
      req_i = 4'hF;
      tick();
      check_vec("mid_ptr0", 32'(gnt_o), 32'h1);
      req_i = '0;

      // Out-of-range angles
      do_reset(2);
      deg_i = {9'd360, 9'd400, 9'd0, 9'd0};
      req_i = 4'b0100;
      tick();
      check_vec("oor_gnt", 32'(gnt_o), 32'h4);
      req_i = '0;
`ifdef CORDIC_SCHED_WRAP_EN
      check_vec("oor_phase", phase, 32'h0000_0028);
      check_vec("oor_busy", 32'(busy_o), 32'd1);
      wait_rsp(n);
      check_vec("oor_lat", 32'(n), 32'd17);
      check_vec("oor_rsp", 32'(rsp_vld_o), 32'h4);
      check_vec("oor_sin", sin_o, fsin(32'h0000_0028));
      tick();
      req_i = 4'b1000;
      tick();
      check_vec("oor360_gnt", 32'(gnt_o), 32'h8);
      check_vec("oor360_phase", phase, 32'h0000_0000);
      req_i = '0;
      wait_rsp(n);
      check_vec("oor360_lat", 32'(n), 32'd17);
      check_vec("oor360_rsp", 32'(rsp_vld_o), 32'h8);
`else
      check_vec("oor_rsp", 32'(rsp_vld_o), 32'h4);
      check_vec("oor_sin", sin_o, 32'hFFFF_FFFF);
      check_vec("oor_cos", cos_o, 32'hFFFF_FFFF);
      check_vec("oor_busy", 32'(busy_o), 32'd0);
      check_vec("oor_phase", phase, 32'd0);
      tick();
      check_vec("oor_rsp_pulse", 32'(rsp_vld_o), 32'd0);
      req_i = 4'b1000;
      tick();
      check_vec("oor360_gnt", 32'(gnt_o), 32'h8);
      check_vec("oor360_rsp", 32'(rsp_vld_o), 32'h8);
      check_vec("oor360_sin", sin_o, 32'hFFFF_FFFF);
      check_vec("oor360_busy", 32'(busy_o), 32'd0);
      req_i = '0;
      hits = 0;
      for (int c = 0; c < 25; c++) begin
         tick();
         if (rsp_vld_o != '0) hits++;
      end
      check_vec("oor_no_late_rsp", 32'(hits), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
